// File: rtl/bit_serial_compare_ctrl.sv
// Bit-serial magnitude comparator controller.
// Walks two latched operands MSB first through an external 1-bit comparator
// and folds its per-bit greater/less/equal answers into a registered result.
module bit_serial_compare_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             cmp_a_out,
  output logic             cmp_b_out,
  input  logic             cmp_g_in,
  input  logic             cmp_l_in,
  input  logic             cmp_e_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             g_t,
  output logic             l_t,
  output logic             e_t,
  output logic             err_out
);

  localparam int unsigned IdxW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    StIdle,
    StCompare,
    StDone
  } state_e;

  state_e           state_q;
  logic [IdxW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  // First deciding bit seen so far (only used when the full word is scanned).
  logic             dec_q;
  logic             dec_g_q;
  logic             dec_l_q;

  logic             onehot;
  logic             dec_now;
  logic             dec_g_now;
  logic             dec_l_now;
  logic             scan_end;

  // Per-bit decision folding: an earlier decision always wins over the current bit.
  always_comb begin
    onehot    = ({cmp_g_in, cmp_l_in, cmp_e_in} == 3'b100) ||
                ({cmp_g_in, cmp_l_in, cmp_e_in} == 3'b010) ||
                ({cmp_g_in, cmp_l_in, cmp_e_in} == 3'b001);
    dec_now   = dec_q | cmp_g_in | cmp_l_in;
    dec_g_now = dec_q ? dec_g_q : cmp_g_in;
    dec_l_now = dec_q ? dec_l_q : cmp_l_in;
    scan_end  = ((EARLY_EXIT != 0) && dec_now) || (idx_q == '0);
  end

  // Bit pair presented to the comparator; quiet outside of the scan.
  always_comb begin
    cmp_a_out = 1'b0;
    cmp_b_out = 1'b0;
    if (state_q == StCompare) begin
      cmp_a_out = a_q[idx_q];
      cmp_b_out = b_q[idx_q];
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dec_q    <= 1'b0;
      dec_g_q  <= 1'b0;
      dec_l_q  <= 1'b0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      g_t      <= 1'b0;
      l_t      <= 1'b0;
      e_t      <= 1'b0;
      err_out  <= 1'b0;
    end else begin
      done_out <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_in) begin
            a_q      <= a_in;
            b_q      <= b_in;
            idx_q    <= IdxW'(WIDTH - 1);
            dec_q    <= 1'b0;
            dec_g_q  <= 1'b0;
            dec_l_q  <= 1'b0;
            g_t      <= 1'b0;
            l_t      <= 1'b0;
            e_t      <= 1'b0;
            err_out  <= 1'b0;
            busy_out <= 1'b1;
            state_q  <= StCompare;
          end
        end
        StCompare: begin
          if (!onehot) begin
            // Comparator protocol violation: abandon the scan with no result.
            err_out  <= 1'b1;
            g_t      <= 1'b0;
            l_t      <= 1'b0;
            e_t      <= 1'b0;
            done_out <= 1'b1;
            state_q  <= StDone;
          end else if (scan_end) begin
            g_t      <= dec_g_now;
            l_t      <= dec_l_now;
            e_t      <= ~dec_now;
            done_out <= 1'b1;
            state_q  <= StDone;
          end else begin
            dec_q    <= dec_now;
            dec_g_q  <= dec_g_now;
            dec_l_q  <= dec_l_now;
            idx_q    <= idx_q - IdxW'(1);
          end
        end
        StDone: begin
          busy_out <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          busy_out <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_compare_ctrl.sv
// Bench for bit_serial_compare_ctrl: one early-exit and one full-scan instance
// share operands and control, each with its own behavioural 1-bit comparator.
module tb_bit_serial_compare_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  int           force_mode;  // 0 = honest comparator, 1 = 000, 2 = 110

  logic ee_cmp_a, ee_cmp_b, ee_g_in, ee_l_in, ee_e_in;
  logic ee_busy, ee_done, ee_g, ee_l, ee_e, ee_err;
  logic fu_cmp_a, fu_cmp_b, fu_g_in, fu_l_in, fu_e_in;
  logic fu_busy, fu_done, fu_g, fu_l, fu_e, fu_err;

  assign ee_g_in = (force_mode == 0) ? (ee_cmp_a & ~ee_cmp_b) : (force_mode == 2);
  assign ee_l_in = (force_mode == 0) ? (~ee_cmp_a & ee_cmp_b) : (force_mode == 2);
  assign ee_e_in = (force_mode == 0) ? ~(ee_cmp_a ^ ee_cmp_b) : 1'b0;
  assign fu_g_in = (force_mode == 0) ? (fu_cmp_a & ~fu_cmp_b) : (force_mode == 2);
  assign fu_l_in = (force_mode == 0) ? (~fu_cmp_a & fu_cmp_b) : (force_mode == 2);
  assign fu_e_in = (force_mode == 0) ? ~(fu_cmp_a ^ fu_cmp_b) : 1'b0;

  bit_serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1)) dut_ee (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .a_in(a_in), .b_in(b_in),
    .cmp_a_out(ee_cmp_a), .cmp_b_out(ee_cmp_b),
    .cmp_g_in(ee_g_in), .cmp_l_in(ee_l_in), .cmp_e_in(ee_e_in),
    .busy_out(ee_busy), .done_out(ee_done),
    .g_t(ee_g), .l_t(ee_l), .e_t(ee_e), .err_out(ee_err)
  );

  bit_serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(0)) dut_fu (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .a_in(a_in), .b_in(b_in),
    .cmp_a_out(fu_cmp_a), .cmp_b_out(fu_cmp_b),
    .cmp_g_in(fu_g_in), .cmp_l_in(fu_l_in), .cmp_e_in(fu_e_in),
    .busy_out(fu_busy), .done_out(fu_done),
    .g_t(fu_g), .l_t(fu_l), .e_t(fu_e), .err_out(fu_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Results captured by run(): latency in edges after accept, {g,l,e}, error, pulse count.
  int           k_ee, k_fu, dn_ee, dn_fu;
  logic [2:0]   r_ee, r_fu;
  logic         x_ee, x_fu;
  logic [W-1:0] ta, tb;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   gle;
    int           k_ee;
    int           k_fu;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Accept one compare and watch both instances for W+2 edges.
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    k_ee = 0; k_fu = 0; dn_ee = 0; dn_fu = 0;
    r_ee = '0; r_fu = '0; x_ee = 1'b0; x_fu = 1'b0; ta = '0; tb = '0;
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    if (hold > 0) begin
      a_in = ~a; b_in = ~b;
    end else begin
      start = 1'b0;
    end
    for (int c = 1; c <= W + 2; c++) begin
      if (c <= W) begin
        ta[W-c] = fu_cmp_a;
        tb[W-c] = fu_cmp_b;
      end
      @(posedge clk); #1;
      if (c >= hold) start = 1'b0;
      if (ee_done) begin
        dn_ee++;
        if (k_ee == 0) begin
          k_ee = c; r_ee = {ee_g, ee_l, ee_e}; x_ee = ee_err;
        end
      end
      if (fu_done) begin
        dn_fu++;
        if (k_fu == 0) begin
          k_fu = c; r_fu = {fu_g, fu_l, fu_e}; x_fu = fu_err;
        end
      end
    end
  endtask

  // Reference: magnitude by integer compare, early-exit latency from the top differing bit.
  function automatic logic [2:0] model_gle(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int model_k_ee(input logic [W-1:0] a, input logic [W-1:0] b);
    int x;
    x = int'(a ^ b);
    if (x == 0) return W;
    return W - ($clog2(x + 1) - 1);
  endfunction

  vec_t vecs[6];

  initial begin
    logic [W-1:0] ra, rb;
    vecs[0] = '{a: 8'hA5, b: 8'hA5, gle: 3'b001, k_ee: 8, k_fu: 8};
    vecs[1] = '{a: 8'h80, b: 8'h7F, gle: 3'b100, k_ee: 1, k_fu: 8};
    vecs[2] = '{a: 8'h12, b: 8'h13, gle: 3'b010, k_ee: 8, k_fu: 8};
    vecs[3] = '{a: 8'h00, b: 8'hFF, gle: 3'b010, k_ee: 1, k_fu: 8};
    vecs[4] = '{a: 8'hFF, b: 8'hFE, gle: 3'b100, k_ee: 8, k_fu: 8};
    vecs[5] = '{a: 8'h3C, b: 8'h34, gle: 3'b100, k_ee: 5, k_fu: 8};

    force_mode = 0;
    start = 1'b0; a_in = '0; b_in = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ee_outs", int'({ee_busy, ee_done, ee_g, ee_l, ee_e, ee_err, ee_cmp_a, ee_cmp_b}), 0);
    chk("reset_fu_outs", int'({fu_busy, fu_done, fu_g, fu_l, fu_e, fu_err, fu_cmp_a, fu_cmp_b}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run(vecs[i].a, vecs[i].b, 0);
      chk($sformatf("tbl%0d_k_ee", i), k_ee, vecs[i].k_ee);
      chk($sformatf("tbl%0d_k_fu", i), k_fu, vecs[i].k_fu);
      chk($sformatf("tbl%0d_gle_ee", i), int'(r_ee), int'(vecs[i].gle));
      chk($sformatf("tbl%0d_gle_fu", i), int'(r_fu), int'(vecs[i].gle));
      chk($sformatf("tbl%0d_err", i), int'({x_ee, x_fu}), 0);
      chk($sformatf("tbl%0d_pulses", i), dn_ee * 10 + dn_fu, 11);
    end

    // Bit-pair trace seen by the comparator, MSB first.
    run(8'h12, 8'h13, 0);
    chk("trace_a", int'(ta), 8'h12);
    chk("trace_b", int'(tb), 8'h13);

    // Random operands against the reference model; bias some toward equality.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = (i % 4 == 0) ? ra : ((i % 4 == 1) ? (ra ^ W'(1 << $urandom_range(W - 1))) : W'($urandom));
      run(ra, rb, 0);
      chk($sformatf("rnd%0d_k_ee", i), k_ee, model_k_ee(ra, rb));
      chk($sformatf("rnd%0d_k_fu", i), k_fu, W);
      chk($sformatf("rnd%0d_gle_ee", i), int'(r_ee), int'(model_gle(ra, rb)));
      chk($sformatf("rnd%0d_gle_fu", i), int'(r_fu), int'(model_gle(ra, rb)));
      chk($sformatf("rnd%0d_pulses", i), dn_ee * 10 + dn_fu, 11);
    end

    // start held through the compare while operand inputs change.
    run(8'h12, 8'h13, 5);
    chk("hold_pulses", dn_ee * 10 + dn_fu, 11);
    chk("hold_gle_ee", int'(r_ee), 3'b010);
    chk("hold_gle_fu", int'(r_fu), 3'b010);
    chk("hold_k_ee", k_ee, 8);

    // start during DONE is dropped; start in the next IDLE is accepted.
    @(negedge clk);
    a_in = 8'h80; b_in = 8'h7F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("dn_first_done", int'(ee_done), 1);
    start = 1'b1;
    @(posedge clk); #1;
    chk("dn_dropped_busy", int'({ee_busy, ee_done}), 0);
    @(posedge clk); #1;
    chk("dn_accept_busy", int'(ee_busy), 1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("dn_second_done", int'({ee_done, ee_g, ee_l, ee_e}), 4'b1100);
    repeat (10) @(posedge clk);

    // Comparator protocol errors on the first compare cycle.
    force_mode = 1;
    run(8'h5A, 8'h5A, 0);
    chk("err000_k", k_ee * 10 + k_fu, 11);
    chk("err000_flag", int'({x_ee, x_fu}), 2'b11);
    chk("err000_gle", int'({r_ee, r_fu}), 0);
    chk("err000_sticky", int'({ee_err, fu_err}), 2'b11);
    force_mode = 2;
    run(8'h5A, 8'h5A, 0);
    chk("err110_k", k_ee * 10 + k_fu, 11);
    chk("err110_flag", int'({x_ee, x_fu}), 2'b11);
    chk("err110_gle", int'({r_ee, r_fu}), 0);
    force_mode = 0;
    run(8'h5A, 8'h5A, 0);
    chk("err_cleared", int'({x_ee, x_fu}), 0);
    chk("err_clr_gle", int'({r_ee, r_fu}), 6'b001001);

    // Asynchronous reset in compare cycle 3 aborts with no completion pulse.
    @(negedge clk);
    a_in = 8'h12; b_in = 8'h13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", int'({ee_busy, fu_busy}), 2'b11);
    rst_n = 1'b0;
    #1;
    chk("rst_async_ee", int'({ee_busy, ee_done, ee_g, ee_l, ee_e, ee_err, ee_cmp_a, ee_cmp_b}), 0);
    chk("rst_async_fu", int'({fu_busy, fu_done, fu_g, fu_l, fu_e, fu_err, fu_cmp_a, fu_cmp_b}), 0);
    dn_ee = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ee_done || fu_done) dn_ee++;
    end
    chk("rst_no_done", dn_ee, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(8'h12, 8'h13, 0);
    chk("post_rst_k", k_ee * 10 + k_fu, 88);
    chk("post_rst_gle", int'({r_ee, r_fu}), 6'b010010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
